// File: rtl/rvcpu_pkg.sv
// Shared definitions for the CPU memory responder.
// Holds the bus field widths, the default address of the tohost
// halt/exit register and the responder FSM state encoding.
package rvcpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    // Byte address of the tohost register. It sits outside any RAM
    // window, so the RAM range check and the tohost match never overlap.
    localparam logic [ADDR_W-1:0] TOHOST_ADDR_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

endpackage

// File: rtl/rvcpu_mem_responder_if.sv
// Load/store bus between the CPU (initiator) and the memory responder.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the responder then holds req_ready low until
// the transaction completes. The response is a single-cycle resp_valid
// pulse with no backpressure, and resp_rdata/resp_err are meaningful only
// while resp_valid is high. At most one request is outstanding.
//
// Modports:
//   master - CPU side: drives req_*, observes req_ready and resp_*
//   slave  - responder side: the reverse
interface rvcpu_mem_responder_if;
    import rvcpu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/rvcpu_sram.sv
// Single-port synchronous RAM of 32-bit words with per-byte write enables.
// Read data is registered (one cycle after the index is presented); a
// write and a read of the same index on the same edge returns the old word.
//
// Ports:
//   clk   - clock
//   idx   - word index
//   we    - write enable
//   be    - byte enables, bit b covers wdata[8b+7:8b]
//   wdata - write data
//   rdata - registered read data
module rvcpu_sram #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/rvcpu_mem_responder.sv
// Memory-side responder for the CPU's single-outstanding load/store bus.
// Serves a word-addressed RAM with byte strobes after LATENCY wait cycles,
// and decodes one tohost word: a full-word store there latches exit_code
// and parks the block in HALT until reset.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - request/response bus (slave side)
//   halted    - sticky, set by a successful tohost store
//   exit_code - value written by that store
//   fsm_state - current FSM state, for observation
module rvcpu_mem_responder
    import rvcpu_pkg::*;
#(
    parameter int                DEPTH_WORDS = 4096,
    parameter int                LATENCY     = 2,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    rvcpu_mem_responder_if.slave    bus,
    output logic                    halted,
    output logic [DATA_W-1:0]       exit_code,
    output state_t                  fsm_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [STRB_W-1:0]  lat_wstrb;

    logic               accept;
    logic               misaligned, in_ram, is_tohost, acc_err;
    logic               tohost_store, ram_we, tohost_we;
    logic [IDX_W-1:0]   ram_idx;
    logic [DATA_W-1:0]  ram_rdata;

    assign accept = (state == ST_IDLE) && bus.req_valid;

    // Decode always works from the latched request, never the live bus.
    assign misaligned   = lat_addr[1:0] != 2'b00;
    assign in_ram       = (lat_addr >> (IDX_W + 2)) == '0;
    assign is_tohost    = lat_addr == TOHOST_ADDR;
    assign acc_err      = misaligned || (!in_ram && !is_tohost) ||
                          (is_tohost && lat_we && lat_wstrb != 4'hF);
    assign tohost_store = lat_we && is_tohost && !acc_err;

    // Commits happen on the edge that ends RESP; an rst on that same edge
    // abandons the transaction, so both write enables are masked by rst.
    assign ram_we    = (state == ST_RESP) && lat_we && in_ram && !acc_err && !rst;
    assign tohost_we = (state == ST_RESP) && tohost_store && !rst;

    // The RAM reads every cycle. In IDLE it is pointed at the live address
    // so that with LATENCY=0 the accept edge itself issues the read; in
    // WAIT/RESP it uses the latched copy, so the word is ready in RESP.
    assign ram_idx = (state == ST_IDLE) ? bus.req_addr[IDX_W+1:2] : lat_addr[IDX_W+1:2];

    rvcpu_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .idx   (ram_idx),
        .we    (ram_we),
        .be    (lat_wstrb),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept) state_next = (LATENCY > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt == CNT_LAST) state_next = ST_RESP;
            ST_RESP: state_next = tohost_store ? ST_HALT : ST_IDLE;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            halted    <= 1'b0;
            exit_code <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_wstrb <= bus.req_wstrb;
            end
            cnt <= (state == ST_WAIT) ? cnt + 1'b1 : '0;
            if (tohost_we) begin
                halted    <= 1'b1;
                exit_code <= lat_wdata;
            end
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    // Masked by rst so a transaction being abandoned never shows a response.
    assign bus.resp_valid = (state == ST_RESP) && !rst;
    assign bus.resp_err   = (state == ST_RESP) && acc_err;
    assign bus.resp_rdata = (state != ST_RESP || acc_err || lat_we) ? '0 :
                            is_tohost ? exit_code : ram_rdata;
    assign fsm_state      = state;

endmodule

// File: tb/tb_rvcpu_mem_responder.sv
module tb_rvcpu_mem_responder;
    import rvcpu_pkg::*;

    logic clk;
    logic rst;

    rvcpu_mem_responder_if bus_a ();
    rvcpu_mem_responder_if bus_b ();

    logic        halted_a, halted_b;
    logic [31:0] exit_a, exit_b;
    state_t      st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    rvcpu_mem_responder #(.LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .halted(halted_a), .exit_code(exit_a), .fsm_state(st_a)
    );

    rvcpu_mem_responder #(.LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .halted(halted_b), .exit_code(exit_b), .fsm_state(st_b)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus_b.req_ready : bus_a.req_ready;
    endfunction

    function automatic logic rv(input bit sel);
        return sel ? bus_b.resp_valid : bus_a.resp_valid;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        if (sel) begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr;
            bus_b.req_wdata = wdata; bus_b.req_wstrb = wstrb;
        end else begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr;
            bus_a.req_wdata = wdata; bus_a.req_wstrb = wstrb;
        end
    endtask

    // Issues one request and waits for its response. Entered and left
    // just after a rising edge. lat = cycles from accept edge to the edge
    // that samples resp_valid.
    task automatic do_req(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output logic err, output int lat);
        bit ok;
        bit seen;
        ok = 0; seen = 0; rdata = '0; err = 1'b0; lat = -1;
        drive(sel, 1'b1, we, addr, wdata, wstrb);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rdy(sel);
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 1'b0, '0, '0, '0);
        check_eq("accepted", 32'(ok), 32'd1);
        if (!ok) return;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rv(sel)) begin
                seen  = 1;
                lat   = k + 1;
                rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
                err   = sel ? bus_b.resp_err : bus_a.resp_err;
                @(negedge clk);
                check_eq("resp_one_cycle", 32'(rv(sel)), 32'd0);
            end
        end
        check_eq("resp_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check_eq("rst_ready",  32'(bus_a.req_ready), 32'd1);
        check_eq("rst_rvalid", 32'(bus_a.resp_valid), 32'd0);
        check_eq("rst_rdata",  bus_a.resp_rdata, 32'd0);
        check_eq("rst_err",    32'(bus_a.resp_err), 32'd0);
        check_eq("rst_halted", 32'(halted_a), 32'd0);
        check_eq("rst_exit",   exit_a, 32'd0);
        check_eq("rst_state",  32'(st_a), 32'(ST_IDLE));
        @(posedge clk); #1;

        // store then load, LATENCY=2
        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check_eq("st10_err", 32'(er), 32'd0);
        check_eq("st10_rdata", rd, 32'd0);
        check_eq("st10_lat", 32'(lat), 32'd3);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check_eq("ld10_data", rd, 32'hDEADBEEF);
        check_eq("ld10_err", 32'(er), 32'd0);
        check_eq("ld10_lat", 32'(lat), 32'd3);

        // byte strobes
        do_req(0, 1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        do_req(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        do_req(0, 0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check_eq("strb_data", rd, 32'h11BB33DD);

        // errors
        do_req(0, 0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        check_eq("mis_err", 32'(er), 32'd1);
        check_eq("mis_rdata", rd, 32'd0);
        do_req(0, 1, 32'h0, 32'h12345678, 4'hF, rd, er, lat);
        do_req(0, 1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        check_eq("oor_err", 32'(er), 32'd1);
        do_req(0, 0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        check_eq("oor_alias_data", rd, 32'h12345678);
        check_eq("oor_alias_err", 32'(er), 32'd0);

        // reset while the store is in WAIT
        do_req(0, 1, 32'h40, 32'h55AA55AA, 4'hF, rd, er, lat);
        drive(0, 1'b1, 1'b1, 32'h40, 32'h0000CAFE, 4'hF);
        @(negedge clk);
        check_eq("mid_ready", 32'(bus_a.req_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        check_eq("mid_in_wait", 32'(st_a), 32'(ST_WAIT));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("mid_no_resp", 32'(bus_a.resp_valid), 32'd0);
        end
        check_eq("mid_ready_after", 32'(bus_a.req_ready), 32'd1);
        check_eq("mid_state_after", 32'(st_a), 32'(ST_IDLE));
        check_eq("mid_rdata_after", bus_a.resp_rdata, 32'd0);
        check_eq("mid_halted_after", 32'(halted_a), 32'd0);
        @(posedge clk); #1;
        do_req(0, 0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check_eq("mid_ram_kept", rd, 32'h55AA55AA);

        // reset on the edge that would commit a store
        do_req(0, 1, 32'h44, 32'h01020304, 4'hF, rd, er, lat);
        drive(0, 1'b1, 1'b1, 32'h44, 32'hFFFF0000, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("resp_rst_state", 32'(st_a), 32'(ST_RESP));
        check_eq("resp_rst_valid", 32'(bus_a.resp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(0, 0, 32'h44, 32'h0, 4'h0, rd, er, lat);
        check_eq("resp_rst_ram_kept", rd, 32'h01020304);

        // tohost
        do_req(0, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        check_eq("th_ld_data", rd, 32'd0);
        check_eq("th_ld_err", 32'(er), 32'd0);
        do_req(0, 1, 32'h8000_0000, 32'h7, 4'h7, rd, er, lat);
        check_eq("th_part_err", 32'(er), 32'd1);
        check_eq("th_part_halted", 32'(halted_a), 32'd0);
        do_req(0, 1, 32'h8000_0000, 32'h0000_0001, 4'hF, rd, er, lat);
        check_eq("th_err", 32'(er), 32'd0);
        check_eq("th_lat", 32'(lat), 32'd3);
        @(negedge clk);
        check_eq("th_halted", 32'(halted_a), 32'd1);
        check_eq("th_exit", exit_a, 32'd1);
        check_eq("th_state", 32'(st_a), 32'(ST_HALT));
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("halt_ready", 32'(bus_a.req_ready), 32'd0);
            check_eq("halt_no_resp", 32'(bus_a.resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        check_eq("halt_sticky", 32'(halted_a), 32'd1);

        // LATENCY=0: preload then 8 back-to-back loads
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = 32'h0BAD_0000 | (32'(i) * 32'h111);
            do_req(1, 1, 32'h100 + 32'(4 * i), v, 4'hF, rd, er, lat);
            check_eq("b_pre_lat", 32'(lat), 32'd1);
            exp_q.push_back(v);
        end
        begin
            int issued;
            int got;
            int last;
            logic acc;
            issued = 0; got = 0; last = -1;
            drive(1, 1'b1, 1'b0, 32'h100, '0, '0);
            for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
                @(negedge clk);
                acc = bus_b.req_valid && bus_b.req_ready;
                if (bus_b.resp_valid) begin
                    check_eq("b2b_data", bus_b.resp_rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX);
                    if (last >= 0) check_eq("b2b_gap", 32'(cyc - last), 32'd2);
                    last = cyc;
                    got++;
                end
                @(posedge clk); #1;
                if (acc) begin
                    issued++;
                    if (issued == 8) drive(1, 1'b0, 1'b0, '0, '0, '0);
                    else bus_b.req_addr = 32'h100 + 32'(4 * issued);
                end
            end
            drive(1, 1'b0, 1'b0, '0, '0, '0);
            check_eq("b2b_count", 32'(got), 32'd8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
